// File: rtl/exc_commit_ctrl_pkg.sv
// Shared CPU definitions: exception codes, CSR op encodings, CSR numbers
// and the commit-controller FSM state type.
package cpu_defs;

    localparam logic [5:0] ECODE_INT = 6'h00;
    localparam logic [5:0] ECODE_ADE = 6'h08;
    localparam logic [5:0] ECODE_ALE = 6'h09;

    localparam logic [1:0] CSR_OP_NONE = 2'b00;
    localparam logic [1:0] CSR_OP_RD   = 2'b01;
    localparam logic [1:0] CSR_OP_WR   = 2'b10;
    localparam logic [1:0] CSR_OP_XCHG = 2'b11;

    localparam logic [13:0] CSR_CRMD   = 14'h000;
    localparam logic [13:0] CSR_PRMD   = 14'h001;
    localparam logic [13:0] CSR_ECFG   = 14'h004;
    localparam logic [13:0] CSR_ESTAT  = 14'h005;
    localparam logic [13:0] CSR_ERA    = 14'h006;
    localparam logic [13:0] CSR_BADV   = 14'h007;
    localparam logic [13:0] CSR_EENTRY = 14'h00C;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_DRAIN = 1'b1
    } commit_state_t;

endpackage

// File: rtl/exc_commit_ctrl_prio.sv
// Combinational commit priority: interrupt > upstream exception > ertn.
module exc_prio_sel
    import cpu_defs::*;
(
    input  logic       take,
    input  logic       int_q,
    input  logic       ex_in,
    input  logic [5:0] ecode_in,
    input  logic [7:0] esubcode_in,
    input  logic       ertn_in,
    output logic       ex,
    output logic [5:0] ecode,
    output logic [7:0] esubcode,
    output logic       ertn
);

    always_comb begin
        ex       = 1'b0;
        ecode    = '0;
        esubcode = '0;
        ertn     = 1'b0;
        if (take) begin
            if (int_q) begin
                ex    = 1'b1;
                ecode = ECODE_INT;
            end else if (ex_in) begin
                ex       = 1'b1;
                ecode    = ecode_in;
                esubcode = esubcode_in;
            end else if (ertn_in) begin
                ertn = 1'b1;
            end
        end
    end

endmodule

// File: rtl/exc_commit_ctrl.sv
// Writeback-stage commit controller: drives the CSR write/exception port,
// issues a registered flush with redirect PC, then drains for FLUSH_CYCLES.
module exc_commit_ctrl
    import cpu_defs::*;
#(
    parameter int unsigned FLUSH_CYCLES = 2
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        wb_valid,
    input  logic [31:0] wb_pc,
    input  logic        wb_ex_in,
    input  logic [5:0]  wb_ecode_in,
    input  logic [7:0]  wb_esubcode_in,
    input  logic [31:0] wb_badaddr,
    input  logic        wb_ertn,
    input  logic [1:0]  wb_csr_op,
    input  logic [13:0] wb_csr_num_in,
    input  logic [31:0] wb_rj_value,
    input  logic [31:0] wb_rd_value,
    input  logic [31:0] csr_rvalue,
    input  logic [31:0] csr_era_pc,
    input  logic [31:0] csr_eentry,
    input  logic [12:0] csr_ecfg_lie,
    input  logic [12:0] csr_estat_is,
    input  logic        csr_crmd_ie,
    output logic [13:0] csr_num,
    output logic        csr_we,
    output logic [31:0] csr_wmask,
    output logic [31:0] csr_wvalue,
    output logic        wb_ex,
    output logic [5:0]  wb_ecode,
    output logic [7:0]  wb_esubcode,
    output logic        wb_ertn_flush,
    output logic        wb_ex_ale,
    output logic [31:0] wb_ex_ale_addr,
    output logic [31:0] csr_rdata_out,
    output logic        commit_ok,
    output logic        flush,
    output logic [31:0] flush_pc,
    output logic        busy
);

    localparam logic [3:0] FLUSH_INIT = 4'(FLUSH_CYCLES);

    commit_state_t state, state_nxt;
    logic [3:0]    cnt, cnt_nxt;
    logic          int_q;
    logic          take;
    logic          redirect;
    logic          csr_write;
    logic          unused;

    // PC is carried for debug visibility only; nothing here consumes it.
    assign unused = ^wb_pc;

    assign take = (state == ST_RUN) && wb_valid;
    assign busy = (state == ST_DRAIN);

    exc_prio_sel u_prio (
        .take        (take),
        .int_q       (int_q),
        .ex_in       (wb_ex_in),
        .ecode_in    (wb_ecode_in),
        .esubcode_in (wb_esubcode_in),
        .ertn_in     (wb_ertn),
        .ex          (wb_ex),
        .ecode       (wb_ecode),
        .esubcode    (wb_esubcode),
        .ertn        (wb_ertn_flush)
    );

    assign redirect       = wb_ex | wb_ertn_flush;
    assign wb_ex_ale      = wb_ex && (wb_ecode == ECODE_ALE);
    assign wb_ex_ale_addr = wb_badaddr;

    assign csr_write     = (wb_csr_op == CSR_OP_WR) || (wb_csr_op == CSR_OP_XCHG);
    assign commit_ok     = take && !redirect;
    assign csr_we        = commit_ok && csr_write;
    assign csr_num       = wb_csr_num_in;
    assign csr_rdata_out = csr_rvalue;
    assign csr_wvalue    = wb_rd_value;

    always_comb begin
        csr_wmask = '0;
        if (csr_we) begin
            csr_wmask = (wb_csr_op == CSR_OP_XCHG) ? wb_rj_value : '1;
        end
    end

    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        case (state)
            ST_RUN: begin
                if (redirect) begin
                    state_nxt = ST_DRAIN;
                    cnt_nxt   = FLUSH_INIT;
                end
            end
            ST_DRAIN: begin
                cnt_nxt = cnt - 4'd1;
                if (cnt <= 4'd1) begin
                    state_nxt = ST_RUN;
                end
            end
            default: state_nxt = ST_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= ST_RUN;
            cnt      <= '0;
            int_q    <= 1'b0;
            flush    <= 1'b0;
            flush_pc <= '0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            int_q <= csr_crmd_ie & (|(csr_estat_is & csr_ecfg_lie));
            flush <= redirect;
            if (redirect) begin
                flush_pc <= wb_ex ? csr_eentry : csr_era_pc;
            end
        end
    end

endmodule

// File: tb/tb_exc_commit_ctrl.sv
// Self-checking bench for exc_commit_ctrl: directed vector table plus
// hand-written interrupt, drain and reset-during-drain sequences.
module tb_exc_commit_ctrl;

    localparam logic [31:0] EENTRY = 32'h1C00_8000;
    localparam logic [31:0] ERA    = 32'h1C00_0100;

    logic        clk = 1'b0;
    logic        rst;
    logic        wb_valid;
    logic [31:0] wb_pc;
    logic        wb_ex_in;
    logic [5:0]  wb_ecode_in;
    logic [7:0]  wb_esubcode_in;
    logic [31:0] wb_badaddr;
    logic        wb_ertn;
    logic [1:0]  wb_csr_op;
    logic [13:0] wb_csr_num_in;
    logic [31:0] wb_rj_value;
    logic [31:0] wb_rd_value;
    logic [31:0] csr_rvalue;
    logic [31:0] csr_era_pc;
    logic [31:0] csr_eentry;
    logic [12:0] csr_ecfg_lie;
    logic [12:0] csr_estat_is;
    logic        csr_crmd_ie;
    logic [13:0] csr_num;
    logic        csr_we;
    logic [31:0] csr_wmask;
    logic [31:0] csr_wvalue;
    logic        wb_ex;
    logic [5:0]  wb_ecode;
    logic [7:0]  wb_esubcode;
    logic        wb_ertn_flush;
    logic        wb_ex_ale;
    logic [31:0] wb_ex_ale_addr;
    logic [31:0] csr_rdata_out;
    logic        commit_ok;
    logic        flush;
    logic [31:0] flush_pc;
    logic        busy;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exc_commit_ctrl #(.FLUSH_CYCLES(2)) dut (
        .clk(clk), .rst(rst), .wb_valid(wb_valid), .wb_pc(wb_pc),
        .wb_ex_in(wb_ex_in), .wb_ecode_in(wb_ecode_in), .wb_esubcode_in(wb_esubcode_in),
        .wb_badaddr(wb_badaddr), .wb_ertn(wb_ertn), .wb_csr_op(wb_csr_op),
        .wb_csr_num_in(wb_csr_num_in), .wb_rj_value(wb_rj_value), .wb_rd_value(wb_rd_value),
        .csr_rvalue(csr_rvalue), .csr_era_pc(csr_era_pc), .csr_eentry(csr_eentry),
        .csr_ecfg_lie(csr_ecfg_lie), .csr_estat_is(csr_estat_is), .csr_crmd_ie(csr_crmd_ie),
        .csr_num(csr_num), .csr_we(csr_we), .csr_wmask(csr_wmask), .csr_wvalue(csr_wvalue),
        .wb_ex(wb_ex), .wb_ecode(wb_ecode), .wb_esubcode(wb_esubcode),
        .wb_ertn_flush(wb_ertn_flush), .wb_ex_ale(wb_ex_ale), .wb_ex_ale_addr(wb_ex_ale_addr),
        .csr_rdata_out(csr_rdata_out), .commit_ok(commit_ok), .flush(flush),
        .flush_pc(flush_pc), .busy(busy)
    );

    typedef struct {
        string       name;
        logic        valid;
        logic        ex_in;
        logic [5:0]  ecode_in;
        logic [7:0]  esub_in;
        logic        ertn;
        logic [1:0]  op;
        logic [13:0] num;
        logic [31:0] rj;
        logic [31:0] rd;
        logic [31:0] rvalue;
        logic [31:0] badaddr;
        logic        e_ex;
        logic [5:0]  e_ecode;
        logic [7:0]  e_esub;
        logic        e_ertn;
        logic        e_we;
        logic [31:0] e_wmask;
        logic        e_ok;
        logic        e_ale;
        logic        e_flush;
        logic [31:0] e_pc;
    } vec_t;

    vec_t vecs[9];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic idle_inputs();
        wb_valid = 1'b0; wb_pc = 32'h1C00_0000; wb_ex_in = 1'b0; wb_ecode_in = '0;
        wb_esubcode_in = '0; wb_badaddr = '0; wb_ertn = 1'b0; wb_csr_op = 2'b00;
        wb_csr_num_in = '0; wb_rj_value = '0; wb_rd_value = '0; csr_rvalue = '0;
    endtask

    task automatic wait_run();
        int n = 0;
        while (busy && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (busy) chk("drain_timeout", 32'(busy), 32'd0);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        csr_era_pc = ERA; csr_eentry = EENTRY;
        csr_ecfg_lie = '0; csr_estat_is = '0; csr_crmd_ie = 1'b0;

        //        name      v  exi ecode  esub   ertn op     num     rj            rd            rvalue  badaddr  ex ecode  esub  ertn we wmask        ok ale fl pc
        vecs[0] = '{"plain",  1, 0, 6'h0,  8'h0,  0, 2'b00, 14'h0,  32'h0,        32'h0,        32'h0,  32'h0,   0, 6'h0,  8'h0, 0, 0, 32'h0,        1, 0, 0, 32'h0};
        vecs[1] = '{"idle",   0, 0, 6'h0,  8'h0,  0, 2'b10, 14'h6,  32'h0,        32'h5,        32'h0,  32'h0,   0, 6'h0,  8'h0, 0, 0, 32'h0,        0, 0, 0, 32'h0};
        vecs[2] = '{"csrrd",  1, 0, 6'h0,  8'h0,  0, 2'b01, 14'h5,  32'h0,        32'h0,        32'h55, 32'h0,   0, 6'h0,  8'h0, 0, 0, 32'h0,        1, 0, 0, 32'h0};
        vecs[3] = '{"csrwr",  1, 0, 6'h0,  8'h0,  0, 2'b10, 14'hC,  32'h0,        32'hDEADBEEF, 32'h11, 32'h0,   0, 6'h0,  8'h0, 0, 1, 32'hFFFFFFFF, 1, 0, 0, 32'h0};
        vecs[4] = '{"csrxchg",1, 0, 6'h0,  8'h0,  0, 2'b11, 14'h4,  32'h0000FF00, 32'h12345678, 32'hAA, 32'h0,   0, 6'h0,  8'h0, 0, 1, 32'h0000FF00, 1, 0, 0, 32'h0};
        vecs[5] = '{"ale",    1, 1, 6'h9,  8'h0,  0, 2'b00, 14'h0,  32'h0,        32'h0,        32'h0,  32'h1003,1, 6'h9,  8'h0, 0, 0, 32'h0,        0, 1, 1, EENTRY};
        vecs[6] = '{"ade_wr", 1, 1, 6'h8,  8'h1,  0, 2'b10, 14'h6,  32'h0,        32'hCAFE,     32'h0,  32'h0,   1, 6'h8,  8'h1, 0, 0, 32'h0,        0, 0, 1, EENTRY};
        vecs[7] = '{"ertn",   1, 0, 6'h0,  8'h0,  1, 2'b00, 14'h0,  32'h0,        32'h0,        32'h0,  32'h0,   0, 6'h0,  8'h0, 1, 0, 32'h0,        0, 0, 1, ERA};
        vecs[8] = '{"ex_ertn",1, 1, 6'hD,  8'h2,  1, 2'b00, 14'h0,  32'h0,        32'h0,        32'h0,  32'h0,   1, 6'hD,  8'h2, 0, 0, 32'h0,        0, 0, 1, EENTRY};

        repeat (2) @(posedge clk);
        @(negedge clk); rst = 1'b0;
        #1;
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_flush", 32'(flush), 32'd0);
        chk("rst_flush_pc", flush_pc, 32'h0);

        foreach (vecs[i]) begin
            @(negedge clk);
            wb_valid = vecs[i].valid; wb_ex_in = vecs[i].ex_in; wb_ecode_in = vecs[i].ecode_in;
            wb_esubcode_in = vecs[i].esub_in; wb_ertn = vecs[i].ertn; wb_csr_op = vecs[i].op;
            wb_csr_num_in = vecs[i].num; wb_rj_value = vecs[i].rj; wb_rd_value = vecs[i].rd;
            csr_rvalue = vecs[i].rvalue; wb_badaddr = vecs[i].badaddr;
            #1;
            chk({vecs[i].name, ".ex"}, 32'(wb_ex), 32'(vecs[i].e_ex));
            chk({vecs[i].name, ".ecode"}, 32'(wb_ecode), 32'(vecs[i].e_ecode));
            chk({vecs[i].name, ".esub"}, 32'(wb_esubcode), 32'(vecs[i].e_esub));
            chk({vecs[i].name, ".ertn"}, 32'(wb_ertn_flush), 32'(vecs[i].e_ertn));
            chk({vecs[i].name, ".we"}, 32'(csr_we), 32'(vecs[i].e_we));
            chk({vecs[i].name, ".wmask"}, csr_wmask, vecs[i].e_wmask);
            if (vecs[i].e_we) chk({vecs[i].name, ".wvalue"}, csr_wvalue, vecs[i].rd);
            chk({vecs[i].name, ".ok"}, 32'(commit_ok), 32'(vecs[i].e_ok));
            chk({vecs[i].name, ".ale"}, 32'(wb_ex_ale), 32'(vecs[i].e_ale));
            if (vecs[i].e_ale) chk({vecs[i].name, ".ale_addr"}, wb_ex_ale_addr, vecs[i].badaddr);
            chk({vecs[i].name, ".num"}, 32'(csr_num), 32'(vecs[i].num));
            chk({vecs[i].name, ".rdata"}, csr_rdata_out, vecs[i].rvalue);
            @(posedge clk); #1;
            chk({vecs[i].name, ".flush"}, 32'(flush), 32'(vecs[i].e_flush));
            chk({vecs[i].name, ".busy"}, 32'(busy), 32'(vecs[i].e_flush));
            if (vecs[i].e_flush) chk({vecs[i].name, ".flush_pc"}, flush_pc, vecs[i].e_pc);
            @(negedge clk);
            idle_inputs();
            wait_run();
        end

        // Interrupt pending one cycle ahead of a csrwr: interrupt wins.
        @(negedge clk);
        csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h0800; csr_estat_is = 13'h0800;
        csr_eentry = 32'h1C00_8000;
        @(negedge clk);
        wb_valid = 1'b1; wb_csr_op = 2'b10; wb_csr_num_in = 14'h6; wb_rd_value = 32'h77;
        #1;
        chk("int.ex", 32'(wb_ex), 32'd1);
        chk("int.ecode", 32'(wb_ecode), 32'd0);
        chk("int.we", 32'(csr_we), 32'd0);
        chk("int.ok", 32'(commit_ok), 32'd0);
        @(posedge clk); #1;
        chk("int.flush", 32'(flush), 32'd1);
        chk("int.flush_pc", flush_pc, 32'h1C00_8000);
        @(negedge clk);
        idle_inputs();
        csr_crmd_ie = 1'b0; csr_ecfg_lie = '0; csr_estat_is = '0;
        wait_run();

        // ertn, drain length, commit latency and interrupt raised during drain.
        @(negedge clk);
        wb_valid = 1'b1; wb_ertn = 1'b1;
        @(posedge clk); #1;
        chk("ertn.flush_c1", 32'(flush), 32'd1);
        chk("ertn.busy_c1", 32'(busy), 32'd1);
        chk("ertn.pc", flush_pc, ERA);
        @(negedge clk);
        wb_ertn = 1'b0;
        csr_crmd_ie = 1'b1; csr_ecfg_lie = 13'h0004; csr_estat_is = 13'h0004;
        #1;
        chk("drain.ok_c1", 32'(commit_ok), 32'd0);
        chk("drain.ex_c1", 32'(wb_ex), 32'd0);
        @(posedge clk); #1;
        chk("ertn.flush_c2", 32'(flush), 32'd0);
        chk("ertn.busy_c2", 32'(busy), 32'd1);
        @(negedge clk); #1;
        chk("drain.ex_c2", 32'(wb_ex), 32'd0);
        @(posedge clk); #1;
        chk("ertn.busy_c3", 32'(busy), 32'd0);
        @(negedge clk); #1;
        chk("drain_int.ex", 32'(wb_ex), 32'd1);
        chk("drain_int.ecode", 32'(wb_ecode), 32'd0);
        @(negedge clk);
        idle_inputs();
        csr_crmd_ie = 1'b0; csr_ecfg_lie = '0; csr_estat_is = '0;
        @(negedge clk);
        wait_run();

        // wb_valid held with csrwr through drain; reset in the first drain cycle.
        @(negedge clk);
        wb_valid = 1'b1; wb_ex_in = 1'b1; wb_ecode_in = 6'h8; wb_csr_op = 2'b10;
        wb_csr_num_in = 14'h1; wb_rd_value = 32'h99;
        @(posedge clk); #1;
        chk("rstd.busy", 32'(busy), 32'd1);
        @(negedge clk);
        wb_ex_in = 1'b0;
        #1;
        chk("rstd.we_drain", 32'(csr_we), 32'd0);
        chk("rstd.ok_drain", 32'(commit_ok), 32'd0);
        rst = 1'b1;
        @(posedge clk); #1;
        chk("rstd.busy_after", 32'(busy), 32'd0);
        chk("rstd.flush_after", 32'(flush), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstd.we_run", 32'(csr_we), 32'd1);
        chk("rstd.ok_run", 32'(commit_ok), 32'd1);
        @(negedge clk);
        idle_inputs();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
